// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg : shared encodings, colour-bar table and MSB replication     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

    typedef enum logic [1:0] {
        FMT_RGB332 = 2'd0,
        FMT_RGB565 = 2'd1,
        FMT_RGB888 = 2'd2,
        FMT_BARS   = 2'd3
    } fmt_t;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Fills cwidth bits MSB-first by cycling through val[nbits-1:0] from its MSB.
    function automatic logic [31:0] replicate(input logic [7:0] val, input int nbits,
                                              input int cwidth);
        logic [31:0] acc;
        logic [2:0]  idx;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < cwidth) begin
                idx = 3'((nbits - 1) - (i % nbits));
                acc = {acc[30:0], val[idx]};
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen : raster counters with active, sync and origin decode |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [HW-1:0] hcnt,
    output logic          active,
    output logic          hs_win,
    output logic          vs_win,
    output logic          origin
);

    localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VW     = ($clog2(VTOTAL + 1) < 2) ? 2 : $clog2(VTOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [VW-1:0] vcnt;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_win = (hcnt >= H_SS) && (hcnt < H_SE);
    assign vs_win = (vcnt >= V_SS) && (vcnt < V_SE);
    assign origin = (hcnt == '0) && (vcnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_pixel_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pixel_engine : stream-to-raster aligner, colour expansion, pins  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_pixel_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PWIDTH   = 24,
    parameter int CWIDTH   = 10
) (
    input  logic              clk_vga,
    input  logic              rst_vga,
    input  logic              enable,
    input  logic [1:0]        fmt,
    input  logic [PWIDTH-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_video_on,
    output logic [CWIDTH-1:0] vga_r,
    output logic [CWIDTH-1:0] vga_g,
    output logic [CWIDTH-1:0] vga_b,
    output logic              frame_start,
    output logic              underflow,
    output logic              misalign,
    input  logic              err_clr
);

    localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HW     = ($clog2(HTOTAL + 1) < 4) ? 4 : $clog2(HTOTAL + 1);
    localparam logic [HW-1:0] BAR_W = HW'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

    logic [HW-1:0] hcnt;
    logic          active, hs_win, vs_win, origin;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW)
    ) u_timing (
        .clk    (clk_vga),
        .rst    (rst_vga),
        .enable (enable),
        .hcnt   (hcnt),
        .active (active),
        .hs_win (hs_win),
        .vs_win (vs_win),
        .origin (origin)
    );

    logic [23:0] pix24;

    generate
        if (PWIDTH >= 24) begin : g_pix_wide
            assign pix24 = pix_data[23:0];
        end else begin : g_pix_narrow
            assign pix24 = {{(24 - PWIDTH){1'b0}}, pix_data};
        end
    endgenerate

    state_t state;
    fmt_t   fmt_lat;
    fmt_t   fmt_eff;
    logic   bars, streaming, sof_beat, misalign_hit, underflow_hit;

    // The origin cycle already runs under the format being latched there.
    assign fmt_eff   = origin ? fmt_t'(fmt) : fmt_lat;
    assign bars      = (fmt_eff == FMT_BARS);
    assign streaming = (state == ST_STREAM) || ((state == ST_WAIT) && origin);
    assign sof_beat  = pix_valid && pix_sof;

    assign misalign_hit  = enable && !bars && streaming && active && !origin && sof_beat;
    assign underflow_hit = enable && !bars && streaming && active && !pix_valid;

    always_comb begin
        pix_ready = 1'b0;
        if (enable && !bars) begin
            if (state == ST_SEEK) begin
                pix_ready = !sof_beat;
            end else begin
                pix_ready = streaming && active && !misalign_hit;
            end
        end
    end

    logic [CWIDTH-1:0] px_r, px_g, px_b;

    always_comb begin
        px_r = '0;
        px_g = '0;
        px_b = '0;
        case (fmt_eff)
            FMT_RGB332: begin
                px_r = CWIDTH'(replicate({5'b0, pix24[7:5]}, 3, CWIDTH));
                px_g = CWIDTH'(replicate({5'b0, pix24[4:2]}, 3, CWIDTH));
                px_b = CWIDTH'(replicate({6'b0, pix24[1:0]}, 2, CWIDTH));
            end
            FMT_RGB565: begin
                px_r = CWIDTH'(replicate({3'b0, pix24[15:11]}, 5, CWIDTH));
                px_g = CWIDTH'(replicate({2'b0, pix24[10:5]}, 6, CWIDTH));
                px_b = CWIDTH'(replicate({3'b0, pix24[4:0]}, 5, CWIDTH));
            end
            FMT_RGB888: begin
                px_r = CWIDTH'(replicate(pix24[23:16], 8, CWIDTH));
                px_g = CWIDTH'(replicate(pix24[15:8], 8, CWIDTH));
                px_b = CWIDTH'(replicate(pix24[7:0], 8, CWIDTH));
            end
            default: ;
        endcase
    end

    logic [HW-1:0]     bar_q;
    logic [2:0]        bar_idx;
    logic [23:0]       bar_rgb;
    logic [CWIDTH-1:0] bar_r, bar_g, bar_b;

    assign bar_q   = hcnt / BAR_W;
    assign bar_idx = (bar_q > HW'(7)) ? 3'd7 : bar_q[2:0];
    assign bar_rgb = BAR_RGB[bar_idx];
    assign bar_r   = CWIDTH'(replicate(bar_rgb[23:16], 8, CWIDTH));
    assign bar_g   = CWIDTH'(replicate(bar_rgb[15:8], 8, CWIDTH));
    assign bar_b   = CWIDTH'(replicate(bar_rgb[7:0], 8, CWIDTH));

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            state        <= ST_SEEK;
            fmt_lat      <= FMT_RGB332;
            vga_hsync    <= ~HS_POL;
            vga_vsync    <= ~VS_POL;
            vga_video_on <= 1'b0;
            vga_r        <= '0;
            vga_g        <= '0;
            vga_b        <= '0;
            frame_start  <= 1'b0;
            underflow    <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            if (!enable) begin
                state        <= ST_SEEK;
                vga_hsync    <= ~HS_POL;
                vga_vsync    <= ~VS_POL;
                vga_video_on <= 1'b0;
                frame_start  <= 1'b0;
            end else begin
                if (origin) begin
                    fmt_lat <= fmt_t'(fmt);
                end
                vga_hsync    <= hs_win ? HS_POL : ~HS_POL;
                vga_vsync    <= vs_win ? VS_POL : ~VS_POL;
                vga_video_on <= active;
                frame_start  <= origin;
                if (bars) begin
                    // Parking in SEEK means leaving bar mode resynchronises on sof.
                    state <= ST_SEEK;
                    if (active) begin
                        vga_r <= bar_r;
                        vga_g <= bar_g;
                        vga_b <= bar_b;
                    end
                end else if (streaming && active) begin
                    if (!pix_valid) begin
                        state <= ST_SEEK;
                    end else if (misalign_hit) begin
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_STREAM;
                        vga_r <= px_r;
                        vga_g <= px_g;
                        vga_b <= px_b;
                    end
                end else if ((state == ST_SEEK) && sof_beat) begin
                    state <= ST_WAIT;
                end
            end
            if (underflow_hit) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
            if (misalign_hit) begin
                misalign <= 1'b1;
            end else if (err_clr) begin
                misalign <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_pixel_engine : randomized stream against a raster-level model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_pixel_engine;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CW = 10;
    localparam int PW = 24;

    logic          clk_vga = 1'b0;
    logic          rst_vga = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    fmt = 2'd0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          err_clr = 1'b0;
    logic          pix_ready, vga_hsync, vga_vsync, vga_video_on;
    logic [CW-1:0] vga_r, vga_g, vga_b;
    logic          frame_start, underflow, misalign;

    vga_pixel_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PWIDTH(PW), .CWIDTH(CW)
    ) dut (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .enable(enable), .fmt(fmt),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_ready(pix_ready), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_video_on(vga_video_on), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .underflow(underflow), .misalign(misalign),
        .err_clr(err_clr)
    );

    always #5 clk_vga = ~clk_vga;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Repeat an n-bit value end to end and keep the top CW bits.
    function automatic logic [CW-1:0] expand(input int x, input int n);
        logic [63:0] acc;
        int total;
        acc = '0;
        total = 0;
        while (total < CW) begin
            acc = (acc << n) | 64'(x);
            total += n;
        end
        return CW'(acc >> (total - CW));
    endfunction

    // ---------------- reference model -----------------
    int            t = 0;      // raster position index, h = t % HT, v = t / HT
    int            mode = 0;   // 0 hunting sof, 1 holding sof for origin, 2 locked
    logic [1:0]    fl = 2'd0;
    logic          m_uf = 1'b0, m_ma = 1'b0;
    logic          e_hs, e_vs, e_von, e_fs;
    logic [CW-1:0] e_r, e_g, e_b;
    bit            known = 0, have_exp = 0;
    bit            xfer = 0;

    always @(negedge clk_vga) begin
        int h, v, bi;
        bit org, act, bars, phase, exp_rdy, uset, mset;
        logic [1:0] fe;
        if (have_exp) begin
            chk("hsync", vga_hsync, e_hs);
            chk("vsync", vga_vsync, e_vs);
            chk("video_on", vga_video_on, e_von);
            chk("frame_start", frame_start, e_fs);
            chk("r", vga_r, e_r);
            chk("g", vga_g, e_g);
            chk("b", vga_b, e_b);
            chk("underflow", underflow, m_uf);
            chk("misalign", misalign, m_ma);
        end
        h = t % HT;
        v = t / HT;
        org = (h == 0) && (v == 0);
        act = (h < HA) && (v < VA);
        fe = org ? fmt : fl;
        bars = (fe == 2'd3);
        phase = (mode == 2) || (mode == 1 && org);
        if (!enable || bars) exp_rdy = 0;
        else if (mode == 0) exp_rdy = !(pix_valid && pix_sof);
        else exp_rdy = phase && act && !(pix_valid && pix_sof && !org);
        if (known) chk("pix_ready", pix_ready, exp_rdy);
        xfer = pix_valid && pix_ready;

        if (rst_vga) begin
            t = 0; mode = 0; fl = 0; m_uf = 0; m_ma = 0;
            e_hs = 1; e_vs = 1; e_von = 0; e_fs = 0; e_r = 0; e_g = 0; e_b = 0;
            known = 1;
            have_exp = 1;
        end else begin
            uset = 0;
            mset = 0;
            e_r = 0; e_g = 0; e_b = 0;
            if (!enable) begin
                t = 0; mode = 0;
                e_hs = 1; e_vs = 1; e_von = 0; e_fs = 0;
            end else begin
                if (org) fl = fmt;
                e_hs = !(h >= HA + HF && h < HA + HF + HS);
                e_vs = !(v >= VA + VF && v < VA + VF + VS);
                e_von = act;
                e_fs = org;
                if (bars) begin
                    mode = 0;
                    if (act) begin
                        bi = h / (HA / 8);
                        e_r = ((bi & 2) == 0) ? '1 : '0;
                        e_g = (bi < 4) ? '1 : '0;
                        e_b = ((bi & 1) == 0) ? '1 : '0;
                    end
                end else if (phase && act) begin
                    if (!pix_valid) begin
                        uset = 1; mode = 0;
                    end else if (pix_sof && !org) begin
                        mset = 1; mode = 1;
                    end else begin
                        mode = 2;
                        if (fe == 2'd0) begin
                            e_r = expand(int'(pix_data[7:5]), 3);
                            e_g = expand(int'(pix_data[4:2]), 3);
                            e_b = expand(int'(pix_data[1:0]), 2);
                        end else if (fe == 2'd1) begin
                            e_r = expand(int'(pix_data[15:11]), 5);
                            e_g = expand(int'(pix_data[10:5]), 6);
                            e_b = expand(int'(pix_data[4:0]), 5);
                        end else begin
                            e_r = expand(int'(pix_data[23:16]), 8);
                            e_g = expand(int'(pix_data[15:8]), 8);
                            e_b = expand(int'(pix_data[7:0]), 8);
                        end
                    end
                end else if (mode == 0 && pix_valid && pix_sof) begin
                    mode = 1;
                end
                t = (t + 1) % (HT * VT);
            end
            m_uf = uset ? 1'b1 : (err_clr ? 1'b0 : m_uf);
            m_ma = mset ? 1'b1 : (err_clr ? 1'b0 : m_ma);
        end
    end

    // ---------------- stream source -----------------
    int src_k = 0;
    bit src_on = 0, src_rand = 0, drop_arm = 0, mis_arm = 0;
    int gap_pct = 0;

    task automatic apply_src();
        if (mis_arm && src_k == 5) begin
            src_k = 0;
            mis_arm = 0;
        end
        pix_valid = src_on;
        if (drop_arm && src_k == 11) begin
            pix_valid = 1'b0;
            drop_arm = 0;
        end
        if (src_on && gap_pct > 0 && $urandom_range(99) < gap_pct) pix_valid = 1'b0;
        pix_sof = src_on && (src_k == 0);
        pix_data = src_rand ? PW'($urandom) : PW'(24'h0000A5);
    endtask

    task automatic cyc();
        @(posedge clk_vga);
        #1;
        if (xfer) src_k = (src_k + 1) % (HA * VA);
        apply_src();
    endtask

    task automatic wait_fs(input string name, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            cyc();
            if (frame_start) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int hs_low, vs_low, beats, en_off;
        bit seen;
        repeat (3) @(posedge clk_vga);
        #1;
        rst_vga = 1'b0;
        chk("rst_hsync", vga_hsync, 1);
        chk("rst_vsync", vga_vsync, 1);
        chk("rst_video_on", vga_video_on, 0);
        chk("rst_ready", pix_ready, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_r", vga_r, 0);
        repeat (3) cyc();

        // Free-running raster, no stream.
        enable = 1'b1;
        repeat (20) cyc();
        chk("seek_ready", pix_ready, 1);
        hs_low = 0;
        vs_low = 0;
        for (int i = 0; i < HT * VT; i++) begin
            cyc();
            if (!vga_hsync) hs_low++;
            if (!vga_vsync) vs_low++;
        end
        chk("hsync_low_per_frame", hs_low, 2 * VT);
        chk("vsync_low_per_frame", vs_low, HT * VS);

        // RGB332 0xA5 stream, garbage beats first.
        src_k = 20;
        src_on = 1;
        apply_src();
        wait_fs("fs_first", 300);
        chk("fs_video_on", vga_video_on, 1);
        chk("a5_r", vga_r, 10'b1011011011);
        chk("a5_g", vga_g, 10'b0010010010);
        chk("a5_b", vga_b, 10'b0101010101);
        beats = 0;
        for (int i = 0; i < HT * VT; i++) begin
            cyc();
            if (xfer) beats++;
        end
        chk("beats_per_frame", beats, HA * VA);

        // Underflow at pixel (3,1).
        drop_arm = 1;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cyc();
            if (underflow) seen = 1;
        end
        chk("underflow_set", 32'(seen), 1);
        repeat (30) cyc();
        chk("underflow_sticky", underflow, 1);
        wait_fs("fs_resync", 300);
        chk("resync_r", vga_r, 10'b1011011011);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        cyc();
        chk("underflow_clr", underflow, 0);

        // sof presented at beat 5.
        mis_arm = 1;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cyc();
            if (misalign) seen = 1;
        end
        chk("misalign_set", 32'(seen), 1);
        wait_fs("fs_after_misalign", 300);
        chk("misalign_held_beat", vga_r, 10'b1011011011);

        // Colour bars, change mid-frame.
        repeat (5) cyc();
        fmt = 2'd3;
        wait_fs("fs_bars", 300);
        chk("bar_white", {vga_r, vga_g, vga_b}, {10'h3FF, 10'h3FF, 10'h3FF});
        cyc();
        chk("bar_yellow", {vga_r, vga_g, vga_b}, {10'h3FF, 10'h3FF, 10'h000});
        fmt = 2'd0;
        #1;
        chk("bars_hold_ready", pix_ready, 0);
        repeat (3 * HT * VT) cyc();

        // Randomized traffic.
        src_rand = 1;
        gap_pct = 4;
        en_off = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(299) == 0) fmt = 2'($urandom_range(3));
            err_clr = ($urandom_range(59) == 0);
            if ($urandom_range(399) == 0) mis_arm = 1;
            if ($urandom_range(499) == 0) en_off = $urandom_range(5, 1);
            enable = (en_off == 0);
            if (en_off > 0) en_off--;
            rst_vga = (i == 2000);
            cyc();
        end
        rst_vga = 1'b0;
        err_clr = 1'b0;
        enable = 1'b1;
        repeat (10) cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
